// File: rtl/ddr4_dqsw_wrlvl_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddr4_dqsw_pkg
// Purpose  : Shared types and constants for the DDR4 DQSW write-leveling
//            sequencer: FSM state encoding, strobe patterns, tap width and a
//            counter-width helper.
// Ports    : none (package)
// Options  : DQSW_EYE_MON_EN (uses ST_CLR / ST_EYEWAIT)
// Revision : 1.0 - initial release
// ============================================================================
package ddr4_dqsw_pkg;

  localparam int TAP_W = 8;

  // Strobe slot cycle 0 drives a single DQS edge with the output enabled
  localparam logic [1:0] C_TX_STROBE = 2'b01;
  localparam logic [1:0] C_OE_STROBE = 2'b11;
  localparam logic [1:0] C_TX_IDLE   = 2'b00;
  localparam logic [1:0] C_OE_IDLE   = 2'b00;

  // ST_FINISH / ST_FAIL name the two outcomes resolved on the DECIDE edge;
  // the sequencer returns straight to ST_IDLE so BUSY falls with DONE/ERROR.
  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LOAD    = 4'd1,
    ST_SETTLE  = 4'd2,
    ST_STROBE  = 4'd3,
    ST_DECIDE  = 4'd4,
    ST_STEP    = 4'd5,
    ST_FINISH  = 4'd6,
    ST_FAIL    = 4'd7,
    ST_CLR     = 4'd8,
    ST_EYEWAIT = 4'd9
  } state_t;

  // Bits needed to hold the value max_val (at least one bit)
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ddr4_dqsw_wrlvl_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ddr4_dqsw_wrlvl_ctrl_if
// Purpose  : Handshake between the PHY training top (master) and the
//            write-leveling sequencer (slave).
// Signals  : start     - one-cycle sweep request (master -> slave)
//            busy      - sweep in progress
//            done      - sticky, edge found
//            error     - sticky, sweep failed
//            tap_out   - tap at which the sweep ended
//            eye_flags - {LATE,EARLY} captured at finish
// Revision : 1.0 - initial release
// ============================================================================
interface ddr4_dqsw_wrlvl_ctrl_if;
  import ddr4_dqsw_pkg::*;

  logic             start;
  logic             busy;
  logic             done;
  logic             error;
  logic [TAP_W-1:0] tap_out;
  logic [1:0]       eye_flags;

  modport master (output start, input busy, done, error, tap_out, eye_flags);
  modport slave  (input start, output busy, done, error, tap_out, eye_flags);

endinterface
`default_nettype wire

// File: rtl/ddr4_dqsw_wrlvl_ctrl_vote.sv
`default_nettype none
// ============================================================================
// Module   : ddr4_dqsw_vote
// Purpose  : Strobe-slot timing and majority vote for one tap. Tracks the
//            cycle within a slot and the slot index, samples the feedback bit
//            RX_LATENCY cycles after each strobe and accumulates the ones.
// Ports    : i_fab_clk, i_arst_n - clock / async active-low reset
//            i_clr       - zero slot position and ones count
//            i_run       - advance slot timing (high in every STROBE cycle)
//            i_rx_bit    - DRAM feedback sample (RX_DATA[0])
//            o_slot_end  - current cycle is the last of its slot
//            o_last_slot - current slot is the final one for this tap
//            o_majority  - ones >= SAMPLE_COUNT/2+1
// Revision : 1.0 - initial release
// ============================================================================
module ddr4_dqsw_vote
  import ddr4_dqsw_pkg::*;
#(
  parameter int SAMPLE_COUNT = 8,
  parameter int STROBE_GAP   = 8,
  parameter int RX_LATENCY   = 4
) (
  input  logic i_fab_clk,
  input  logic i_arst_n,
  input  logic i_clr,
  input  logic i_run,
  input  logic i_rx_bit,
  output logic o_slot_end,
  output logic o_last_slot,
  output logic o_majority
);

  localparam int GAP_W  = cnt_w(STROBE_GAP - 1);
  localparam int SLOT_W = cnt_w(SAMPLE_COUNT - 1);
  localparam int ONES_W = cnt_w(SAMPLE_COUNT);

  localparam logic [GAP_W-1:0]  C_GAP_LAST  = GAP_W'(STROBE_GAP - 1);
  localparam logic [GAP_W-1:0]  C_SAMPLE_AT = GAP_W'(RX_LATENCY);
  localparam logic [SLOT_W-1:0] C_SLOT_LAST = SLOT_W'(SAMPLE_COUNT - 1);
  localparam logic [ONES_W-1:0] C_THRESH    = ONES_W'(SAMPLE_COUNT / 2 + 1);

  logic [GAP_W-1:0]  r_cyc;
  logic [SLOT_W-1:0] r_slot;
  logic [ONES_W-1:0] r_ones;

  always_ff @(posedge i_fab_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_cyc  <= '0;
      r_slot <= '0;
      r_ones <= '0;
    end else if (i_clr) begin
      r_cyc  <= '0;
      r_slot <= '0;
      r_ones <= '0;
    end else if (i_run) begin
      // Strobe left the IOD in slot cycle 0; its echo is valid RX_LATENCY later
      if (r_cyc == C_SAMPLE_AT) begin
        r_ones <= r_ones + ONES_W'(i_rx_bit);
      end
      if (r_cyc == C_GAP_LAST) begin
        r_cyc  <= '0;
        r_slot <= (r_slot == C_SLOT_LAST) ? '0 : r_slot + SLOT_W'(1);
      end else begin
        r_cyc <= r_cyc + GAP_W'(1);
      end
    end
  end

  assign o_slot_end  = (r_cyc == C_GAP_LAST);
  assign o_last_slot = (r_slot == C_SLOT_LAST);
  assign o_majority  = (r_ones >= C_THRESH);

endmodule
`default_nettype wire

// File: rtl/ddr4_dqsw_wrlvl_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ddr4_dqsw_wrlvl_ctrl
// Purpose  : Write-leveling sequencer for one DDR4 byte lane. Sweeps the DQSW
//            delay line from tap 0 upward, fires SAMPLE_COUNT strobes per tap,
//            majority-votes the DQ feedback and stops at the first 0->1
//            transition (DONE) or on out-of-range / last tap (ERROR).
// Ports    : i_fab_clk, i_arst_n          - clock / async active-low reset
//            ctrl_if (slave)              - start/busy/done/error/tap_out/eye_flags
//            o_tx_data, o_oe_data         - IOD TX_DATA_0 / OE_DATA_0
//            o_delay_line_load/move/direction, i_delay_line_out_of_range
//            o_eye_monitor_clear_flags, i_eye_monitor_early/late
//            i_rx_data                    - IOD RX_DATA_0, bit 0 is feedback
// Options  : DQSW_EYE_MON_EN - clear and capture the eye monitor after the
//            edge is found (adds 1+SETTLE_CYCLES cycles before DONE)
// Revision : 1.0 - initial release
// ============================================================================
module ddr4_dqsw_wrlvl_ctrl
  import ddr4_dqsw_pkg::*;
#(
  parameter int MAX_TAPS      = 128,
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLE_COUNT  = 8,
  parameter int STROBE_GAP    = 8,
  parameter int RX_LATENCY    = 4
) (
  input  logic                         i_fab_clk,
  input  logic                         i_arst_n,
  ddr4_dqsw_wrlvl_ctrl_if.slave        ctrl_if,
  output logic [1:0]                   o_tx_data,
  output logic [1:0]                   o_oe_data,
  output logic                         o_delay_line_load,
  output logic                         o_delay_line_move,
  output logic                         o_delay_line_direction,
  input  logic                         i_delay_line_out_of_range,
  output logic                         o_eye_monitor_clear_flags,
  input  logic                         i_eye_monitor_early,
  input  logic                         i_eye_monitor_late,
  input  logic [1:0]                   i_rx_data
);

  localparam int SET_W = cnt_w(SETTLE_CYCLES - 1);
  localparam logic [SET_W-1:0] C_SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [TAP_W-1:0] C_TAP_LAST    = TAP_W'(MAX_TAPS - 1);

  state_t             r_state;
  logic [TAP_W-1:0]   r_tap;
  logic [SET_W-1:0]   r_settle_cnt;
  logic               r_seen_zero;
  logic               r_busy;
  logic               r_done;
  logic               r_error;
  logic [TAP_W-1:0]   r_tap_out;
  logic [1:0]         r_tx;
  logic [1:0]         r_oe;
  logic               r_load;
  logic               r_move;
  logic               r_dir;

  logic w_slot_end;
  logic w_last_slot;
  logic w_majority;
  logic w_vote_clr;
  logic w_vote_run;
  logic w_edge_found;
  logic w_fail;

  // Bit 1 of the RX bus carries nothing for write leveling
  logic w_unused_rx;
  assign w_unused_rx = i_rx_data[1];

  // Vote state is held clear while idle (covers START) and on every tap step
  assign w_vote_clr = (r_state == ST_IDLE) || (r_state == ST_STEP);
  assign w_vote_run = (r_state == ST_STROBE);

  ddr4_dqsw_vote #(
    .SAMPLE_COUNT (SAMPLE_COUNT),
    .STROBE_GAP   (STROBE_GAP),
    .RX_LATENCY   (RX_LATENCY)
  ) u_vote (
    .i_fab_clk   (i_fab_clk),
    .i_arst_n    (i_arst_n),
    .i_clr       (w_vote_clr),
    .i_run       (w_vote_run),
    .i_rx_bit    (i_rx_data[0]),
    .o_slot_end  (w_slot_end),
    .o_last_slot (w_last_slot),
    .o_majority  (w_majority)
  );

  // Out-of-range outranks everything; a 1 only counts after some 0 was seen
  assign w_edge_found = !i_delay_line_out_of_range && w_majority && r_seen_zero;
  assign w_fail       = i_delay_line_out_of_range || (r_tap == C_TAP_LAST);

`ifdef DQSW_EYE_MON_EN
  logic       r_eye_clr;
  logic [1:0] r_eye_flags;
`else
  logic w_unused_eye;
  assign w_unused_eye = i_eye_monitor_early ^ i_eye_monitor_late;
`endif

  always_ff @(posedge i_fab_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state      <= ST_IDLE;
      r_tap        <= '0;
      r_settle_cnt <= '0;
      r_seen_zero  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_tap_out    <= '0;
      r_tx         <= C_TX_IDLE;
      r_oe         <= C_OE_IDLE;
      r_load       <= 1'b0;
      r_move       <= 1'b0;
      r_dir        <= 1'b0;
`ifdef DQSW_EYE_MON_EN
      r_eye_clr    <= 1'b0;
      r_eye_flags  <= 2'b00;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ctrl_if.start) begin
            r_state     <= ST_LOAD;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_tap_out   <= '0;
            r_seen_zero <= 1'b0;
            r_tap       <= '0;
            r_busy      <= 1'b1;
            r_dir       <= 1'b1;
            r_load      <= 1'b1;
`ifdef DQSW_EYE_MON_EN
            r_eye_flags <= 2'b00;
`endif
          end
        end

        ST_LOAD: begin
          r_load       <= 1'b0;
          r_settle_cnt <= '0;
          r_state      <= ST_SETTLE;
        end

        ST_SETTLE: begin
          if (r_settle_cnt == C_SETTLE_LAST) begin
            // First STROBE cycle is slot cycle 0
            r_state <= ST_STROBE;
            r_tx    <= C_TX_STROBE;
            r_oe    <= C_OE_STROBE;
          end else begin
            r_settle_cnt <= r_settle_cnt + SET_W'(1);
          end
        end

        ST_STROBE: begin
          // Outputs are registered, so the pattern is set one cycle ahead
          if (w_slot_end && w_last_slot) begin
            r_state <= ST_DECIDE;
            r_tx    <= C_TX_IDLE;
            r_oe    <= C_OE_IDLE;
          end else if (w_slot_end) begin
            r_tx <= C_TX_STROBE;
            r_oe <= C_OE_STROBE;
          end else begin
            r_tx <= C_TX_IDLE;
            r_oe <= C_OE_IDLE;
          end
        end

        ST_DECIDE: begin
          if (!i_delay_line_out_of_range && !w_majority) begin
            r_seen_zero <= 1'b1;
          end
          if (w_edge_found) begin
`ifdef DQSW_EYE_MON_EN
            r_state   <= ST_CLR;
            r_eye_clr <= 1'b1;
`else
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_dir     <= 1'b0;
            r_done    <= 1'b1;
            r_tap_out <= r_tap;
`endif
          end else if (w_fail) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_dir     <= 1'b0;
            r_error   <= 1'b1;
            r_tap_out <= r_tap;
          end else begin
            r_state <= ST_STEP;
            r_move  <= 1'b1;
          end
        end

        ST_STEP: begin
          r_move       <= 1'b0;
          r_tap        <= r_tap + TAP_W'(1);
          r_settle_cnt <= '0;
          r_state      <= ST_SETTLE;
        end

`ifdef DQSW_EYE_MON_EN
        ST_CLR: begin
          r_eye_clr    <= 1'b0;
          r_settle_cnt <= '0;
          r_state      <= ST_EYEWAIT;
        end

        ST_EYEWAIT: begin
          // Let the monitor re-accumulate at the found tap before capturing
          if (r_settle_cnt == C_SETTLE_LAST) begin
            r_eye_flags <= {i_eye_monitor_late, i_eye_monitor_early};
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_dir       <= 1'b0;
            r_done      <= 1'b1;
            r_tap_out   <= r_tap;
          end else begin
            r_settle_cnt <= r_settle_cnt + SET_W'(1);
          end
        end
`endif

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_dir   <= 1'b0;
          r_tx    <= C_TX_IDLE;
          r_oe    <= C_OE_IDLE;
          r_load  <= 1'b0;
          r_move  <= 1'b0;
        end
      endcase
    end
  end

  assign ctrl_if.busy            = r_busy;
  assign ctrl_if.done            = r_done;
  assign ctrl_if.error           = r_error;
  assign ctrl_if.tap_out         = r_tap_out;
  assign o_tx_data               = r_tx;
  assign o_oe_data               = r_oe;
  assign o_delay_line_load       = r_load;
  assign o_delay_line_move       = r_move;
  assign o_delay_line_direction  = r_dir;

`ifdef DQSW_EYE_MON_EN
  assign ctrl_if.eye_flags         = r_eye_flags;
  assign o_eye_monitor_clear_flags = r_eye_clr;
`else
  assign ctrl_if.eye_flags         = 2'b00;
  assign o_eye_monitor_clear_flags = 1'b0;
`endif

endmodule
`default_nettype wire
